// File: rtl/lc3_control.sv
// LC-3 multicycle control unit: Moore FSM; all strobes decode from state and IR.
// Instruction latency FETCH0->FETCH0: 4 (NOP), 5 (ALU/BR/JMP/LEA), 7 (LD/LDR/ST/STR).
module lc3_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        flagWE,
  output logic        memWE,
  output logic [1:0]  selPC,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        selMAR,
  output logic        selMDR,
  output logic [2:0]  DR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [1:0]  aluControl,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_FETCH0, ST_FETCH1, ST_FETCH2, ST_DECODE, ST_ALU, ST_BR, ST_JMP,
    ST_LEA, ST_ADDR, ST_RD, ST_WB, ST_STD, ST_WR, ST_HALT
  } state_t;

  state_t     st;
  logic [3:0] opcode;
  logic       br_taken;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  assign br_taken  = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
  assign unused_ir = ^IR[5:3];
  assign state     = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= ST_FETCH0;
    end else begin
      case (st)
        ST_FETCH0: st <= ST_FETCH1;
        ST_FETCH1: st <= ST_FETCH2;
        ST_FETCH2: st <= ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            4'b0001, 4'b0101, 4'b1001:          st <= ST_ALU;
            4'b0000:                            st <= ST_BR;
            4'b1100:                            st <= ST_JMP;
            4'b1110:                            st <= ST_LEA;
            4'b0010, 4'b0110, 4'b0011, 4'b0111: st <= ST_ADDR;
            4'b1111:                            st <= ST_HALT;
            default:                            st <= ST_FETCH0;
          endcase
        end
        // Opcode bit 12 separates stores (ST/STR) from loads (LD/LDR).
        ST_ADDR: st <= IR[12] ? ST_STD : ST_RD;
        ST_RD:   st <= ST_WB;
        ST_STD:  st <= ST_WR;
        ST_HALT: st <= ST_HALT;
        default: st <= ST_FETCH0;
      endcase
    end
  end

  always_comb begin
    enaPC      = 1'b0;
    enaMDR     = 1'b0;
    enaALU     = 1'b0;
    enaMARM    = 1'b0;
    ldPC       = 1'b0;
    ldIR       = 1'b0;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    regWE      = 1'b0;
    flagWE     = 1'b0;
    memWE      = 1'b0;
    selPC      = 2'b00;
    selEAB1    = 1'b0;
    selEAB2    = 2'b00;
    selMAR     = 1'b0;
    selMDR     = 1'b0;
    DR         = IR[11:9];
    SR1        = IR[8:6];
    SR2        = IR[2:0];
    aluControl = 2'b00;
    case (st)
      ST_FETCH0: begin
        enaPC = 1'b1;
        ldMAR = 1'b1;
        ldPC  = 1'b1;
      end
      ST_FETCH1: begin
        ldMDR  = 1'b1;
        selMDR = 1'b1;
      end
      ST_FETCH2: begin
        enaMDR = 1'b1;
        ldIR   = 1'b1;
      end
      ST_ALU: begin
        enaALU = 1'b1;
        regWE  = 1'b1;
        flagWE = 1'b1;
        case (opcode)
          4'b0101: aluControl = 2'b01;
          4'b1001: aluControl = 2'b10;
          default: aluControl = 2'b00;
        endcase
      end
      ST_BR: begin
        if (br_taken) begin
          ldPC    = 1'b1;
          selPC   = 2'b01;
          selEAB2 = 2'b10;
        end
      end
      ST_JMP: begin
        ldPC    = 1'b1;
        selPC   = 2'b01;
        selEAB1 = 1'b1;
      end
      ST_LEA: begin
        enaMARM = 1'b1;
        selEAB2 = 2'b10;
        regWE   = 1'b1;
        flagWE  = 1'b1;
      end
      ST_ADDR: begin
        ldMAR   = 1'b1;
        enaMARM = 1'b1;
        // LDR/STR (opcode bit 14 set) use base register + offset6.
        if (IR[14]) begin
          selEAB1 = 1'b1;
          selEAB2 = 2'b01;
        end else begin
          selEAB2 = 2'b10;
        end
      end
      ST_RD: begin
        ldMDR  = 1'b1;
        selMDR = 1'b1;
      end
      ST_WB: begin
        enaMDR = 1'b1;
        regWE  = 1'b1;
        flagWE = 1'b1;
      end
      ST_STD: begin
        enaALU     = 1'b1;
        aluControl = 2'b11;
        SR1        = IR[11:9];
        ldMDR      = 1'b1;
      end
      ST_WR: memWE = 1'b1;
      default: ;
    endcase
    if (reset) begin
      enaPC   = 1'b0;
      enaMDR  = 1'b0;
      enaALU  = 1'b0;
      enaMARM = 1'b0;
      ldPC    = 1'b0;
      ldIR    = 1'b0;
      ldMAR   = 1'b0;
      ldMDR   = 1'b0;
      regWE   = 1'b0;
      flagWE  = 1'b0;
      memWE   = 1'b0;
    end
  end

endmodule

// File: tb/tb_lc3_control.sv
// Bench for lc3_control: instruction-level path model plus directed literal checks.
module tb_lc3_control;

  localparam int F0 = 0, F1 = 1, F2 = 2, DEC = 3, SALU = 4, SBR = 5, SJMP = 6,
                 SLEA = 7, SADDR = 8, SRD = 9, SWB = 10, SSTD = 11, SWR = 12, SHALT = 13;

  typedef struct packed {
    logic ena_pc, ena_mdr, ena_alu, ena_marm;
    logic ld_pc, ld_ir, ld_mar, ld_mdr, reg_we, flag_we, mem_we;
    logic [1:0] sel_pc;
    logic       sel_eab1;
    logic [1:0] sel_eab2;
    logic       sel_mar, sel_mdr;
    logic [2:0] dr, sr1, sr2;
    logic [1:0] alu;
    logic [3:0] st;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] IR;
  logic N, Z, P;
  logic enaPC, enaMDR, enaALU, enaMARM, ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE, memWE;
  logic [1:0] selPC, selEAB2, aluControl;
  logic selEAB1, selMAR, selMDR;
  logic [2:0] DR, SR1, SR2;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  int m_state = F0;
  int path[$];
  bit armed = 0;
  bit mem_seen = 0;
  out_t act, exp_o;

  always #5 clk = ~clk;

  lc3_control dut (
    .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .P(P),
    .enaPC(enaPC), .enaMDR(enaMDR), .enaALU(enaALU), .enaMARM(enaMARM),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .regWE(regWE), .flagWE(flagWE), .memWE(memWE),
    .selPC(selPC), .selEAB1(selEAB1), .selEAB2(selEAB2), .selMAR(selMAR), .selMDR(selMDR),
    .DR(DR), .SR1(SR1), .SR2(SR2), .aluControl(aluControl), .state(state)
  );

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Whole-instruction state walk that follows FETCH0 for a given opcode.
  function automatic void build_path(input logic [15:0] ir);
    int op;
    op = int'(ir[15:12]);
    path.push_back(F1);
    path.push_back(F2);
    path.push_back(DEC);
    if (op == 1 || op == 5 || op == 9) begin path.push_back(SALU); path.push_back(F0); end
    else if (op == 0)  begin path.push_back(SBR);  path.push_back(F0); end
    else if (op == 12) begin path.push_back(SJMP); path.push_back(F0); end
    else if (op == 14) begin path.push_back(SLEA); path.push_back(F0); end
    else if (op == 2 || op == 6) begin
      path.push_back(SADDR); path.push_back(SRD); path.push_back(SWB); path.push_back(F0);
    end else if (op == 3 || op == 7) begin
      path.push_back(SADDR); path.push_back(SSTD); path.push_back(SWR); path.push_back(F0);
    end else if (op == 15) path.push_back(SHALT);
    else path.push_back(F0);
  endfunction

  function automatic out_t exp_out(input int s, input logic [15:0] ir, input logic n,
                                   input logic z, input logic p, input logic rst);
    out_t o;
    int op;
    op    = int'(ir[15:12]);
    o     = '0;
    o.dr  = ir[11:9];
    o.sr1 = ir[8:6];
    o.sr2 = ir[2:0];
    o.st  = 4'(s);
    if (s == F0) begin o.ena_pc = 1; o.ld_mar = 1; o.ld_pc = 1; end
    if (s == F1) begin o.ld_mdr = 1; o.sel_mdr = 1; end
    if (s == F2) begin o.ena_mdr = 1; o.ld_ir = 1; end
    if (s == SALU) begin
      o.ena_alu = 1; o.reg_we = 1; o.flag_we = 1;
      o.alu = (op == 5) ? 2'd1 : (op == 9) ? 2'd2 : 2'd0;
    end
    if (s == SBR && ((ir[11] && n) || (ir[10] && z) || (ir[9] && p))) begin
      o.ld_pc = 1; o.sel_pc = 2'd1; o.sel_eab2 = 2'd2;
    end
    if (s == SJMP) begin o.ld_pc = 1; o.sel_pc = 2'd1; o.sel_eab1 = 1; end
    if (s == SLEA) begin o.ena_marm = 1; o.sel_eab2 = 2'd2; o.reg_we = 1; o.flag_we = 1; end
    if (s == SADDR) begin
      o.ld_mar = 1; o.ena_marm = 1;
      if (op == 6 || op == 7) begin o.sel_eab1 = 1; o.sel_eab2 = 2'd1; end
      else o.sel_eab2 = 2'd2;
    end
    if (s == SRD) begin o.ld_mdr = 1; o.sel_mdr = 1; end
    if (s == SWB) begin o.ena_mdr = 1; o.reg_we = 1; o.flag_we = 1; end
    if (s == SSTD) begin o.ena_alu = 1; o.alu = 2'd3; o.sr1 = ir[11:9]; o.ld_mdr = 1; end
    if (s == SWR) o.mem_we = 1;
    if (rst) begin
      {o.ena_pc, o.ena_mdr, o.ena_alu, o.ena_marm} = '0;
      {o.ld_pc, o.ld_ir, o.ld_mar, o.ld_mdr, o.reg_we, o.flag_we, o.mem_we} = '0;
    end
    return o;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_state = F0;
      path.delete();
      armed = 1;
    end else if (armed) begin
      if (m_state == F0 && path.size() == 0) build_path(IR);
      if (path.size() != 0) m_state = path.pop_front();
    end
  end

  always_comb begin
    act = {enaPC, enaMDR, enaALU, enaMARM, ldPC, ldIR, ldMAR, ldMDR, regWE, flagWE, memWE,
           selPC, selEAB1, selEAB2, selMAR, selMDR, DR, SR1, SR2, aluControl, state};
  end

  always @(negedge clk) begin
    if (armed) begin
      exp_o = exp_out(m_state, IR, N, Z, P, reset);
      chk("cycle_outputs", 64'(act), 64'(exp_o));
      chk("one_bus_driver", 64'($countones({enaPC, enaMDR, enaALU, enaMARM}) <= 1), 64'd1);
      if (memWE) mem_seen = 1;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic measure(input string name, input logic [15:0] ir, input int required);
    int cnt;
    IR  = ir;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (state != 4'(F0) && cnt < 30);
    chk(name, 64'(cnt), 64'(required));
  endtask

  initial begin
    reset = 1; IR = 16'h1261; N = 0; Z = 0; P = 0;
    tick(2);
    chk("reset_state", 64'(state), 64'(F0));
    chk("reset_ldpc_off", 64'(ldPC), 64'd0);
    reset = 0;
    #1;
    chk("first_fetch_enapc", 64'(enaPC), 64'd1);
    chk("first_fetch_ldmar", 64'(ldMAR), 64'd1);
    tick(); chk("add_f1", 64'(state), 64'(F1));
    tick(); chk("add_f2", 64'(state), 64'(F2));
    tick(); chk("add_dec", 64'(state), 64'(DEC));
    tick(); chk("add_alu", 64'(state), 64'(SALU));
    chk("add_alu_fields", 64'({enaALU, regWE, flagWE, DR, SR1, aluControl}),
        64'({1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 2'b00}));
    tick(); chk("add_back_f0", 64'(state), 64'(F0));

    IR = 16'h0402; Z = 1;
    tick(4);
    chk("brz_taken", 64'({ldPC, selPC, selEAB2}), 64'({1'b1, 2'b01, 2'b10}));
    tick();
    Z = 0; N = 1; P = 0;
    tick(4);
    chk("brz_not_taken", 64'(ldPC), 64'd0);
    tick();
    IR = 16'h0000; N = 1; Z = 1; P = 1;
    tick(4);
    chk("br_nzp000_never", 64'(ldPC), 64'd0);
    tick();
    N = 0; Z = 0; P = 0;

    IR = 16'h7642;
    tick(4);
    chk("str_addr", 64'({state, SR1, selEAB1, selEAB2, ldMAR}),
        64'({4'(SADDR), 3'd1, 1'b1, 2'b01, 1'b1}));
    tick();
    chk("str_std", 64'({state, SR1, aluControl, ldMDR}), 64'({4'(SSTD), 3'd3, 2'b11, 1'b1}));
    tick();
    chk("str_wr", 64'({state, memWE}), 64'({4'(SWR), 1'b1}));
    tick();
    chk("str_back_f0", 64'(state), 64'(F0));

    IR = 16'h2405;
    tick(4);
    chk("ld_addr", 64'({state, selEAB1, selEAB2}), 64'({4'(SADDR), 1'b0, 2'b10}));
    tick();
    chk("ld_rd", 64'({state, ldMDR, selMDR}), 64'({4'(SRD), 1'b1, 1'b1}));
    tick();
    chk("ld_wb", 64'({state, enaMDR, regWE, DR}), 64'({4'(SWB), 1'b1, 1'b1, 3'd2}));
    tick();
    IR = 16'hD000;
    tick(3);
    chk("nop_dec", 64'(state), 64'(DEC));
    tick();
    chk("nop_f0", 64'(state), 64'(F0));

    measure("lat_and", 16'h5262, 5);
    measure("lat_not", 16'h927F, 5);
    measure("lat_jmp", 16'hC1C0, 5);
    measure("lat_lea", 16'hE005, 5);
    measure("lat_ldr", 16'h6642, 7);
    measure("lat_st",  16'h3403, 7);
    measure("lat_nop", 16'h8000, 4);

    IR = 16'hF025;
    tick(4);
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", 64'(state), 64'(SHALT));
      chk("halt_strobes", 64'({enaPC, enaMDR, enaALU, enaMARM, ldPC, ldIR, ldMAR, ldMDR,
                               regWE, flagWE, memWE}), 64'd0);
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    chk("halt_reset_f0", 64'(state), 64'(F0));

    IR = 16'h2405;
    mem_seen = 0;
    tick(5);
    chk("mid_rd", 64'(state), 64'(SRD));
    reset = 1;
    tick();
    chk("mid_reset_f0", 64'(state), 64'(F0));
    reset = 0;
    tick();
    chk("mid_reset_f1", 64'(state), 64'(F1));
    tick(6);
    chk("no_memwe_on_load", 64'(mem_seen), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
